// File: rtl/dmem_port_arbiter.sv
// Serialises the two issue lanes onto the single data-memory port, A before B.
// Optional DMEM_ARB_PERF_EN adds access / pair-stall / flush-drop counters.
module dmem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                a_valid,
  input  logic [DATA_W/8-1:0] a_we,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic                a_ready,
  input  logic                b_valid,
  input  logic [DATA_W/8-1:0] b_we,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic                b_ready,
  output logic                resp_a_valid,
  output logic [DATA_W-1:0]   resp_a_rdata,
  output logic                resp_b_valid,
  output logic [DATA_W-1:0]   resp_b_rdata,
  output logic                pair_stall,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0]   dmem_wdata,
  output logic [DATA_W/8-1:0] dmem_we,
  output logic                dmem_re,
  input  logic [DATA_W-1:0]   dmem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_accesses,
  output logic [31:0]         perf_pair_stalls,
  output logic [31:0]         perf_flush_drops
`endif
);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t state;
  logic   grant_a, grant_b, pair_req;
  logic   resp_pend, resp_sel, resp_rd;

  // Grants are gated by reset so every output reads 0 while reset is held.
  always_comb begin
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    pair_req = 1'b0;
    if (reset && !flush) begin
      if (state == IDLE) begin
        grant_a  = a_valid;
        grant_b  = b_valid && !a_valid;
        pair_req = a_valid && b_valid;
      end else begin
        grant_b  = b_valid;
      end
    end
  end

  always_comb begin
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_we    = '0;
    dmem_re    = 1'b0;
    if (grant_a) begin
      dmem_addr  = a_addr;
      dmem_wdata = a_wdata;
      dmem_we    = a_we;
      dmem_re    = ~|a_we;
    end else if (grant_b) begin
      dmem_addr  = b_addr;
      dmem_wdata = b_wdata;
      dmem_we    = b_we;
      dmem_re    = ~|b_we;
    end
  end

  assign a_ready    = grant_a;
  assign b_ready    = grant_b;
  assign pair_stall = pair_req;

  // resp_sel: 0 = lane A, 1 = lane B; resp_rd marks a load needing dmem_rdata.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      resp_pend <= 1'b0;
      resp_sel  <= 1'b0;
      resp_rd   <= 1'b0;
    end else begin
      state     <= pair_req ? SECOND : IDLE;
      resp_pend <= grant_a || grant_b;
      resp_sel  <= grant_b;
      resp_rd   <= grant_b ? ~|b_we : ~|a_we;
    end
  end

  assign resp_a_valid = resp_pend && !resp_sel;
  assign resp_b_valid = resp_pend && resp_sel;
  assign resp_a_rdata = (resp_a_valid && resp_rd) ? dmem_rdata : '0;
  assign resp_b_rdata = (resp_b_valid && resp_rd) ? dmem_rdata : '0;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_accesses    <= '0;
      perf_pair_stalls <= '0;
      perf_flush_drops <= '0;
    end else begin
      if (grant_a || grant_b)
        perf_accesses <= perf_accesses + 32'd1;
      if (pair_req)
        perf_pair_stalls <= perf_pair_stalls + 32'd1;
      if (state == SECOND && flush && b_valid)
        perf_flush_drops <= perf_flush_drops + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomised bench for dmem_port_arbiter against a program-order memory scoreboard.
module tb_dmem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [3:0]  a_we, b_we, dmem_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        resp_a_valid, resp_b_valid, pair_stall, dmem_re;
  logic [31:0] resp_a_rdata, resp_b_rdata, dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata = '0;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_accesses, perf_pair_stalls, perf_flush_drops;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem[256];
  logic [31:0] ref_mem[256];

  // Scoreboard state: whether B is still owed, and the response due next cycle.
  bit          b_owed = 0;
  bit          exp_ra = 0, exp_rb = 0;
  logic [31:0] exp_rdata = '0;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ready(a_ready),
    .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ready(b_ready),
    .resp_a_valid(resp_a_valid), .resp_a_rdata(resp_a_rdata),
    .resp_b_valid(resp_b_valid), .resp_b_rdata(resp_b_rdata),
    .pair_stall(pair_stall),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_re(dmem_re),
    .dmem_rdata(dmem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .perf_accesses(perf_accesses), .perf_pair_stalls(perf_pair_stalls),
    .perf_flush_drops(perf_flush_drops)
`endif
  );

  always #5 clk = ~clk;

  // Memory behind the port: read data one cycle after dmem_re, byte-masked writes.
  always @(posedge clk) begin
    logic [31:0] w;
    if (dmem_re) dmem_rdata <= mem[dmem_addr[9:2]];
    w = mem[dmem_addr[9:2]];
    for (int i = 0; i < 4; i++)
      if (dmem_we[i]) w[8*i +: 8] = dmem_wdata[8*i +: 8];
    if (|dmem_we) mem[dmem_addr[9:2]] <= w;
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (we[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " a_ready"}, a_ready, 0);
    checkOutput({tag, " b_ready"}, b_ready, 0);
    checkOutput({tag, " pair_stall"}, pair_stall, 0);
    checkOutput({tag, " resp_a_valid"}, resp_a_valid, 0);
    checkOutput({tag, " resp_b_valid"}, resp_b_valid, 0);
    checkOutput({tag, " resp_a_rdata"}, resp_a_rdata, 0);
    checkOutput({tag, " resp_b_rdata"}, resp_b_rdata, 0);
    checkOutput({tag, " dmem_port"}, {dmem_addr, dmem_wdata}, 0);
    checkOutput({tag, " dmem_we_re"}, {dmem_we, dmem_re}, 0);
  endtask

  // One cycle: drive a bundle, check every output, then advance the scoreboard.
  task automatic applyStimulus(input bit av, input bit bv, input bit fl,
                               input logic [3:0] awe, input logic [31:0] aad, input logic [31:0] awd,
                               input logic [3:0] bwe, input logic [31:0] bad, input logic [31:0] bwd);
    bit ga, gb, ps;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_we;
    bit          e_re;
    @(negedge clk);
    a_valid = av; b_valid = bv; flush = fl;
    a_we = awe; a_addr = aad; a_wdata = awd;
    b_we = bwe; b_addr = bad; b_wdata = bwd;
    #1;
    // A is always served first; a pair owes B the following cycle.
    ga = 0; gb = 0; ps = 0;
    if (!fl) begin
      if (b_owed) gb = bv;
      else begin
        ga = av;
        gb = bv && !av;
        ps = av && bv;
      end
    end
    e_addr = 0; e_wdata = 0; e_we = 0; e_re = 0;
    if (ga) begin e_addr = aad; e_wdata = awd; e_we = awe; e_re = (awe == 0); end
    if (gb) begin e_addr = bad; e_wdata = bwd; e_we = bwe; e_re = (bwe == 0); end

    checkOutput("resp_a_valid", resp_a_valid, exp_ra);
    checkOutput("resp_b_valid", resp_b_valid, exp_rb);
    checkOutput("resp_a_rdata", resp_a_rdata, exp_ra ? exp_rdata : 32'h0);
    checkOutput("resp_b_rdata", resp_b_rdata, exp_rb ? exp_rdata : 32'h0);
    checkOutput("a_ready", a_ready, ga);
    checkOutput("b_ready", b_ready, gb);
    checkOutput("pair_stall", pair_stall, ps);
    checkOutput("dmem_addr", dmem_addr, e_addr);
    checkOutput("dmem_wdata", dmem_wdata, e_wdata);
    checkOutput("dmem_we", dmem_we, e_we);
    checkOutput("dmem_re", dmem_re, e_re);

    exp_ra = ga;
    exp_rb = gb;
    exp_rdata = 0;
    if (ga) begin
      if (awe == 0) exp_rdata = ref_mem[aad[9:2]];
      else ref_mem[aad[9:2]] = merge(ref_mem[aad[9:2]], awd, awe);
    end
    if (gb) begin
      if (bwe == 0) exp_rdata = ref_mem[bad[9:2]];
      else ref_mem[bad[9:2]] = merge(ref_mem[bad[9:2]], bwd, bwe);
    end
    b_owed = ps;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 0;
    #2;
    reset = 1;
    b_owed = 0; exp_ra = 0; exp_rb = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [3:0]  awe, bwe;
    logic [31:0] aad, awd, bad, bwd;
    bit          av, bv, fl;

    for (int i = 0; i < 256; i++) begin
      mem[i] = (i * 32'h01010101) ^ 32'hA5A50000;
      ref_mem[i] = mem[i];
    end
    mem[64] = 32'hDEADBEEF;
    ref_mem[64] = 32'hDEADBEEF;

    // Reset with both lanes requesting: everything must still read 0.
    reset = 0; flush = 0;
    a_valid = 1; b_valid = 1; a_we = 4'hF; b_we = 4'hF;
    a_addr = 32'h44; b_addr = 32'h48; a_wdata = 32'h1; b_wdata = 32'h2;
    #12;
    checkAllZero("reset");
`ifdef DMEM_ARB_PERF_EN
    checkOutput("perf_reset", {perf_accesses, perf_pair_stalls}, 0);
`endif
    a_valid = 0; b_valid = 0;
    @(negedge clk);
    reset = 1;

    applyStimulus(1, 0, 0, 4'h0, 32'h100, 32'h0, 4'h0, 32'h0, 32'h0);
    idle();

    applyStimulus(1, 1, 0, 4'hF, 32'h40, 32'h12345678, 4'h0, 32'h40, 32'h0);
    applyStimulus(1, 1, 0, 4'hF, 32'h40, 32'h12345678, 4'h0, 32'h40, 32'h0);
    idle();

    applyStimulus(0, 1, 0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h8, 32'h0);
    applyStimulus(1, 0, 0, 4'hF, 32'hC, 32'hCAFE0001, 4'h0, 32'h0, 32'h0);
    idle();

    applyStimulus(1, 1, 0, 4'h0, 32'h10, 32'h0, 4'h3, 32'h14, 32'h55667788);
    applyStimulus(1, 1, 1, 4'h0, 32'h10, 32'h0, 4'h3, 32'h14, 32'h55667788);
    idle();
    applyStimulus(1, 0, 0, 4'h0, 32'h14, 32'h0, 4'h0, 32'h0, 32'h0);
    idle();

    // Reset in the owed-B cycle: B (a store to 0x20) must never reach memory.
    applyStimulus(1, 1, 0, 4'h0, 32'h18, 32'h0, 4'hF, 32'h20, 32'hBADBAD00);
    @(negedge clk);
    #2;
    reset = 0;
    #1;
    checkAllZero("reset_second");
    @(posedge clk);
    #2;
    a_valid = 0; b_valid = 0;
    reset = 1;
    b_owed = 0; exp_ra = 0; exp_rb = 0;
    idle();
    applyStimulus(1, 0, 0, 4'h0, 32'h20, 32'h0, 4'h0, 32'h0, 32'h0);
    idle();

    // Random bundles; a paired bundle is held until B is accepted.
    awe = 0; bwe = 0; aad = 0; bad = 0; awd = 0; bwd = 0;
    for (int n = 0; n < 400; n++) begin
      if (b_owed) begin
        av = 1; bv = 1;
        fl = ($urandom_range(0, 4) == 0);
      end else begin
        av = $urandom_range(0, 1);
        bv = $urandom_range(0, 1);
        fl = ($urandom_range(0, 9) == 0);
        awe = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
        bwe = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
        aad = {26'h0, 4'($urandom_range(0, 7)), 2'b00};
        bad = {26'h0, 4'($urandom_range(0, 7)), 2'b00};
        awd = $urandom;
        bwd = $urandom;
      end
      applyStimulus(av, bv, fl, awe, aad, awd, bwe, bad, bwd);
    end
    idle();

`ifdef DMEM_ARB_PERF_EN
    doReset();
    for (int p = 0; p < 3; p++) begin
      applyStimulus(1, 1, 0, 4'h0, 32'h4, 32'h0, 4'h0, 32'h8, 32'h0);
      applyStimulus(1, 1, 0, 4'h0, 32'h4, 32'h0, 4'h0, 32'h8, 32'h0);
    end
    applyStimulus(1, 0, 0, 4'h0, 32'hC, 32'h0, 4'h0, 32'h0, 32'h0);
    applyStimulus(0, 1, 0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h10, 32'h0);
    idle();
    checkOutput("perf_accesses", perf_accesses, 8);
    checkOutput("perf_pair_stalls", perf_pair_stalls, 3);
    checkOutput("perf_flush_drops", perf_flush_drops, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
